// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, one full-adder bit per clock
// Optional signed-overflow output enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_bit;
    logic             w_carry_nxt;
    logic             w_last;
    logic             w_load;
    logic             w_run;

    assign w_run       = (r_state == ST_RUN);
    assign w_last      = w_run && (r_cnt == CW'(WIDTH - 1));
    assign w_bit       = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B at load and seed the carry with ctrl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= b ^ {WIDTH{ctrl}};
            r_carry <= ctrl;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_s     <= {w_bit, r_s[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_carry_nxt;
`ifdef SERIAL_ADD_SUB_OVF_EN
                // r_carry here is still the carry into the MSB.
                ovf    <= r_carry ^ w_carry_nxt;
`endif
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;
    assign cout = r_cout;

endmodule
